alu_seq: RTL and testbench

- Registered, handshaked successor of the combinational ALU for the datapath.
- Width-parametrised, with a 4-bit opcode space.
- Computes real N/Z/C/V flags and adds an iterative multiplier.
- Sits between the register-file read stage and the write-back stage; valid/ready on both sides isolates it from pipeline stalls.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_seq_mul_iter.sv | 63 ++++++
 rtl/alu_seq.sv | 188 ++++++++++++++++++
 tb/tb_alu_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, flag bit positions, FSM states
// and the flag-vector packing helper.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_SHL = 4'd2,
        OP_SHR = 4'd3,
        OP_OR  = 4'd4,
        OP_AND = 4'd5,
        OP_XOR = 4'd6,
        OP_NOT = 4'd7,
        OP_MUL = 4'd8,
        OP_CMP = 4'd9
    } alu_op_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

    function automatic logic [3:0] make_flags(input logic c, input logic n,
                                              input logic v, input logic z);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_V] = v;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// step counter runs BITS-1 down to 0, product presented combinationally on the last step.
module mul_iter #(
    parameter int BITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BITS-1:0]   op_a,
    input  logic [BITS-1:0]   op_b,
    output logic              done,
    output logic [2*BITS-1:0] product
);
    localparam int CW = $clog2(BITS);

    logic [CW-1:0]     count_r;
    logic              busy_r;
    logic [2*BITS-1:0] acc_r;
    logic [2*BITS-1:0] mcand_r;
    logic [BITS-1:0]   mplier_r;
    logic [2*BITS-1:0] acc_next_s;

    // Partial-product accumulation for the current multiplier bit
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // The completing step's sum is forwarded so the caller can register it on that same edge
    assign done    = busy_r && (count_r == {CW{1'b0}});
    assign product = acc_next_s;

    // Operand load on start, then one shift-add step per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r   <= 1'b0;
            count_r  <= {CW{1'b0}};
            acc_r    <= {(2*BITS){1'b0}};
            mcand_r  <= {(2*BITS){1'b0}};
            mplier_r <= {BITS{1'b0}};
        end else if (start) begin
            busy_r   <= 1'b1;
            count_r  <= CW'(BITS - 1);
            acc_r    <= {(2*BITS){1'b0}};
            mcand_r  <= {{BITS{1'b0}}, op_a};
            mplier_r <= op_b;
        end else if (busy_r) begin
            acc_r    <= acc_next_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            if (count_r == {CW{1'b0}}) begin
                busy_r <= 1'b0;
            end else begin
                count_r <= count_r - CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered, valid/ready handshaked ALU with N/Z/C/V flags and an iterative
// multiplier; single-cycle ops complete on the accepting edge.
module alu_seq
    import alu_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [BITS-1:0] bus_a_i,
    input  logic [BITS-1:0] bus_b_i,
    input  logic [3:0]      control_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [BITS-1:0] bus_s_o,
    output logic [3:0]      flags_o
);
    localparam int SHW = $clog2(BITS) + 1;
    localparam logic [BITS-1:0] BITS_LIM = BITS'(BITS);

    alu_state_e        state_r;
    alu_state_e        state_next_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              mul_start_s;
    logic              mul_done_s;
    logic [2*BITS-1:0] mul_product_s;
    logic [3:0]        mul_flags_s;

    logic [BITS:0]     sum_s;
    logic [BITS:0]     diff_s;
    logic [BITS:0]     shl_s;
    logic [BITS:0]     shr_s;
    logic [SHW-1:0]    amt_s;
    logic              amt_big_s;
    logic [BITS-1:0]   res_s;
    logic [BITS-1:0]   flag_val_s;
    logic              c_s;
    logic              v_s;
    logic              flags_clr_s;
    logic [3:0]        flags_s;

    assign in_ready_s  = !rst_i && (state_r == IDLE) && (!out_valid_o || out_ready_i);
    assign in_ready_o  = in_ready_s;
    assign accept_s    = in_valid_i && in_ready_s;
    assign mul_start_s = accept_s && (control_i == OP_MUL);

    mul_iter #(.BITS(BITS)) u_mul (
        .clk     (clk_i),
        .rst     (rst_i),
        .start   (mul_start_s),
        .op_a    (bus_a_i),
        .op_b    (bus_b_i),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    assign mul_flags_s = make_flags(|mul_product_s[2*BITS-1:BITS],
                                    mul_product_s[BITS-1], 1'b0,
                                    mul_product_s[BITS-1:0] == {BITS{1'b0}});

    // The extra bit of each shifter catches the last bit shifted out
    assign sum_s     = {1'b0, bus_a_i} + {1'b0, bus_b_i};
    assign diff_s    = {1'b0, bus_a_i} - {1'b0, bus_b_i};
    assign amt_s     = bus_b_i[SHW-1:0];
    assign amt_big_s = (bus_b_i >= BITS_LIM);
    assign shl_s     = {1'b0, bus_a_i} << amt_s;
    assign shr_s     = {bus_a_i, 1'b0} >> amt_s;

    // Single-cycle result and flag computation
    always_comb begin
        res_s       = {BITS{1'b0}};
        flag_val_s  = {BITS{1'b0}};
        c_s         = 1'b0;
        v_s         = 1'b0;
        flags_clr_s = 1'b0;
        case (alu_op_e'(control_i))
            OP_ADD: begin
                res_s = sum_s[BITS-1:0];
                c_s   = sum_s[BITS];
                v_s   = (bus_a_i[BITS-1] == bus_b_i[BITS-1]) &&
                        (sum_s[BITS-1] != bus_a_i[BITS-1]);
            end
            OP_SUB, OP_CMP: begin
                c_s = !diff_s[BITS];
                v_s = (bus_a_i[BITS-1] != bus_b_i[BITS-1]) &&
                      (diff_s[BITS-1] != bus_a_i[BITS-1]);
                if (control_i == OP_CMP) begin
                    res_s = bus_a_i;
                end else begin
                    res_s = diff_s[BITS-1:0];
                end
            end
            OP_SHL: begin
                if (amt_big_s) begin
                    res_s = {BITS{1'b0}};
                    c_s   = 1'b0;
                end else begin
                    res_s = shl_s[BITS-1:0];
                    c_s   = shl_s[BITS];
                end
            end
            OP_SHR: begin
                if (amt_big_s) begin
                    res_s = {BITS{1'b0}};
                    c_s   = 1'b0;
                end else begin
                    res_s = shr_s[BITS:1];
                    c_s   = shr_s[0];
                end
            end
            OP_OR:   res_s = bus_a_i | bus_b_i;
            OP_AND:  res_s = bus_a_i & bus_b_i;
            OP_XOR:  res_s = bus_a_i ^ bus_b_i;
            OP_NOT:  res_s = ~bus_a_i;
            OP_MUL:  res_s = {BITS{1'b0}};
            default: begin
                res_s       = bus_a_i ^ bus_b_i;
                flags_clr_s = 1'b1;
            end
        endcase
        // CMP reports flags of A-B while presenting A on the result bus
        if (control_i == OP_CMP) begin
            flag_val_s = diff_s[BITS-1:0];
        end else begin
            flag_val_s = res_s;
        end
        if (flags_clr_s) begin
            flags_s = 4'b0000;
        end else begin
            flags_s = make_flags(c_s, flag_val_s[BITS-1], v_s,
                                 flag_val_s == {BITS{1'b0}});
        end
    end

    // FSM next-state: MUL is held until the multiplier signals its last step
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (mul_start_s) begin
                    state_next_s = MUL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MUL: begin
                if (mul_done_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = MUL;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Output register: load on completion, otherwise hold until drained
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            bus_s_o     <= {BITS{1'b0}};
            flags_o     <= 4'b0000;
        end else if (accept_s && !mul_start_s) begin
            out_valid_o <= 1'b1;
            bus_s_o     <= res_s;
            flags_o     <= flags_s;
        end else if ((state_r == MUL) && mul_done_s) begin
            out_valid_o <= 1'b1;
            bus_s_o     <= mul_product_s[BITS-1:0];
            flags_o     <= mul_flags_s;
        end else if (out_valid_o && out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (BITS=8): expected results are queued when an op is
// driven and checked by a monitor whenever a result transfers.
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct {
        string      name;
        logic [7:0] res;
        logic [3:0] flags;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] bus_a;
    logic [7:0] bus_b;
    logic [3:0] control;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] bus_s;
    logic [3:0] flags;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   w;
    int   k;
    logic saw;

    alu_seq #(.BITS(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .bus_a_i     (bus_a),
        .bus_b_i     (bus_b),
        .control_i   (control),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .bus_s_o     (bus_s),
        .flags_o     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive one op; returns #1 after the accepting edge, waits = stall cycles
    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int waits);
        control  = op;
        bus_a    = a;
        bus_b    = b;
        in_valid = 1'b1;
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 50) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input string name, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] er, input logic [3:0] ef,
                        output int waits);
        exp_t e;
        e.name  = name;
        e.res   = er;
        e.flags = ef;
        exp_q.push_back(e);
        drive(op, a, b, waits);
    endtask

    // scoreboard monitor: every transfer must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("no_stale_result", 32'(out_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_res"}, 32'(bus_s), 32'(mon_e.res));
                check({mon_e.name, "_flags"}, 32'(flags), 32'(mon_e.flags));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        bus_a     = 8'h00;
        bus_b     = 8'h00;
        control   = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_bus", 32'(bus_s), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        @(posedge clk);
        #1;

        // flags order {C,N,V,Z}
        send("add_ovf",  OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0110, w);
        send("add_wrap", OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1001, w);
        check("b2b_add", 32'(w), 32'd0);
        send("sub_eq",   OP_SUB, 8'h05, 8'h05, 8'h00, 4'b1001, w);
        check("b2b_sub", 32'(w), 32'd0);
        send("cmp_lt",   OP_CMP, 8'h03, 8'h04, 8'h03, 4'b0100, w);
        send("shl_1",    OP_SHL, 8'h81, 8'h01, 8'h02, 4'b1000, w);
        send("shr_9",    OP_SHR, 8'h81, 8'h09, 8'h00, 4'b0001, w);
        send("shl_0",    OP_SHL, 8'h5A, 8'h00, 8'h5A, 4'b0000, w);
        send("shr_1",    OP_SHR, 8'h81, 8'h01, 8'h40, 4'b1000, w);
        send("shr_8",    OP_SHR, 8'h81, 8'h08, 8'h00, 4'b0001, w);
        send("or",       OP_OR,  8'hF0, 8'h0F, 8'hFF, 4'b0100, w);
        send("and",      OP_AND, 8'hF0, 8'h0F, 8'h00, 4'b0001, w);
        send("xor",      OP_XOR, 8'hA5, 8'hFF, 8'h5A, 4'b0000, w);
        send("not",      OP_NOT, 8'h00, 8'h33, 8'hFF, 4'b0100, w);
        send("rsvd",     4'd12,  8'hA5, 8'h0F, 8'hAA, 4'b0000, w);
        send("sub_ovf",  OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b1010, w);

        // MUL latency and busy behaviour
        send("mul_hi", OP_MUL, 8'h10, 8'h10, 8'h00, 4'b1001, w);
        k   = 0;
        saw = in_ready;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
            if (!out_valid && in_ready) saw = 1'b1;
        end
        check("mul_latency", 32'(k), 32'd8);
        check("mul_busy_ready", 32'(saw), 32'd0);
        send("mul_lo", OP_MUL, 8'h0F, 8'h0F, 8'hE1, 4'b0100, w);
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("mul2_latency", 32'(k), 32'd8);
        repeat (2) @(posedge clk);
        #1;

        // backpressure: result held, next op stalled, then transfer + accept together
        out_ready = 1'b0;
        send("bp_add", OP_ADD, 8'h01, 8'h02, 8'h03, 4'b0000, w);
        exp_q.push_back('{name: "bp_next", res: 8'h05, flags: 4'b1000});
        control  = OP_SUB;
        bus_a    = 8'h09;
        bus_b    = 8'h04;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold", 32'(bus_s), 32'h03);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset in the middle of a multiply
        drive(OP_MUL, 8'h33, 8'h07, w);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_bus", 32'(bus_s), 32'd0);
        check("mrst_flags", 32'(flags), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mrst_ready", 32'(in_ready), 32'd1);
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        check("mrst_no_output", 32'(saw), 32'd0);
        @(posedge clk);
        #1;
        send("post_rst", OP_ADD, 8'h02, 8'h03, 8'h05, 4'b0000, w);
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
